// File: rtl/du_pkg.sv
// rtl/du_pkg.sv - shared field widths, bundle sizing and skid-buffer state encoding for the decode unit
package du_pkg;

    localparam int RD_W    = 5;
    localparam int OPC_W   = 7;
    localparam int F3_W    = 3;
    localparam int F7_W    = 7;
    localparam int SHAMT_W = 6;

    // Bundle layout, MSB first: instAddr, rdAddr, rdWe, rs1, rs2, imm, opCode, funct3, funct7, shamt, pID
    function automatic int du_bundle_w(input int addr_w, input int xlen, input int pid_w);
        return addr_w + RD_W + 1 + 3 * xlen + OPC_W + F3_W + F7_W + SHAMT_W + pid_w;
    endfunction

    // Encoding is {main_valid, skid_valid}; 2'b01 cannot occur
    typedef enum logic [1:0] {
        SB_EMPTY = 2'b00,
        SB_ONE   = 2'b10,
        SB_TWO   = 2'b11
    } sb_state_e;

endpackage

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - generic 2-entry skid buffer with registered ready and flush
module skid_buffer
    import du_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    sb_state_e        state_q, state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_xfer;
    logic             out_xfer;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;

    assign in_ready  = (state_q != SB_TWO) && !rst;
    assign out_valid = state_q[1];
    assign out_data  = main_q;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            SB_EMPTY: begin
                if (in_xfer) begin
                    load_main = 1'b1;
                    state_d   = SB_ONE;
                end
            end
            SB_ONE: begin
                if (in_xfer && out_xfer) begin
                    load_main = 1'b1;
                end else if (in_xfer) begin
                    load_skid = 1'b1;
                    state_d   = SB_TWO;
                end else if (out_xfer) begin
                    state_d = SB_EMPTY;
                end
            end
            SB_TWO: begin
                if (out_xfer) begin
                    main_from_skid = 1'b1;
                    state_d        = SB_ONE;
                end
            end
            default: state_d = SB_EMPTY;
        endcase
        // Flush wins over any concurrent transfer; payload is left untouched
        if (flush) begin
            state_d        = SB_EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SB_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main) begin
                main_q <= in_data;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/du_reg_way1.sv
// rtl/du_reg_way1.sv - way1 decode-to-execute pipeline register built on a 2-entry skid buffer
module du_reg_way1
    import du_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 64,
    parameter int PID_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [ADDR_W-1:0]  instAddr_i,
    input  logic [RD_W-1:0]    rdAddr_i,
    input  logic               rdWriteEnable_i,
    input  logic [XLEN-1:0]    rs1ReadData_i,
    input  logic [XLEN-1:0]    rs2ReadData_i,
    input  logic [XLEN-1:0]    imm_i,
    input  logic [OPC_W-1:0]   opCode_i,
    input  logic [F3_W-1:0]    funct3_i,
    input  logic [F7_W-1:0]    funct7_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [PID_W-1:0]   pID_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [ADDR_W-1:0]  instAddr_o,
    output logic [RD_W-1:0]    rdAddr_o,
    output logic               rdWriteEnable_o,
    output logic [XLEN-1:0]    rs1ReadData_o,
    output logic [XLEN-1:0]    rs2ReadData_o,
    output logic [XLEN-1:0]    imm_o,
    output logic [OPC_W-1:0]   opCode_o,
    output logic [F3_W-1:0]    funct3_o,
    output logic [F7_W-1:0]    funct7_o,
    output logic [SHAMT_W-1:0] shamt_o,
    output logic [PID_W-1:0]   pID_o
);

    localparam int BUNDLE_W = du_bundle_w(ADDR_W, XLEN, PID_W);

    logic [BUNDLE_W-1:0] bundle_in;
    logic [BUNDLE_W-1:0] bundle_out;
    logic                rd_we_held;

    assign bundle_in = {instAddr_i, rdAddr_i, rdWriteEnable_i, rs1ReadData_i, rs2ReadData_i,
                        imm_i, opCode_i, funct3_i, funct7_i, shamt_i, pID_i};

    skid_buffer #(
        .WIDTH(BUNDLE_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush_i),
        .in_valid (valid_i),
        .in_ready (ready_o),
        .in_data  (bundle_in),
        .out_valid(valid_o),
        .out_ready(ready_i),
        .out_data (bundle_out)
    );

    assign {instAddr_o, rdAddr_o, rd_we_held, rs1ReadData_o, rs2ReadData_o,
            imm_o, opCode_o, funct3_o, funct7_o, shamt_o, pID_o} = bundle_out;

    // A stale write enable must never reach the EU once the bundle has left
    assign rdWriteEnable_o = rd_we_held && valid_o;

endmodule

// File: tb/tb_du_reg_way1.sv
// tb/tb_du_reg_way1.sv - directed and randomized self-checking bench for du_reg_way1
module tb_du_reg_way1;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] instAddr_i;
    logic [4:0]  rdAddr_i;
    logic        rdWriteEnable_i;
    logic [63:0] rs1ReadData_i;
    logic [63:0] rs2ReadData_i;
    logic [63:0] imm_i;
    logic [6:0]  opCode_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [5:0]  shamt_i;
    logic [1:0]  pID_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instAddr_o;
    logic [4:0]  rdAddr_o;
    logic        rdWriteEnable_o;
    logic [63:0] rs1ReadData_o;
    logic [63:0] rs2ReadData_o;
    logic [63:0] imm_o;
    logic [6:0]  opCode_o;
    logic [2:0]  funct3_o;
    logic [6:0]  funct7_o;
    logic [5:0]  shamt_o;
    logic [1:0]  pID_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    du_reg_way1 dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .instAddr_i     (instAddr_i),
        .rdAddr_i       (rdAddr_i),
        .rdWriteEnable_i(rdWriteEnable_i),
        .rs1ReadData_i  (rs1ReadData_i),
        .rs2ReadData_i  (rs2ReadData_i),
        .imm_i          (imm_i),
        .opCode_i       (opCode_i),
        .funct3_i       (funct3_i),
        .funct7_i       (funct7_i),
        .shamt_i        (shamt_i),
        .pID_i          (pID_i),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .instAddr_o     (instAddr_o),
        .rdAddr_o       (rdAddr_o),
        .rdWriteEnable_o(rdWriteEnable_o),
        .rs1ReadData_o  (rs1ReadData_o),
        .rs2ReadData_o  (rs2ReadData_o),
        .imm_o          (imm_o),
        .opCode_o       (opCode_o),
        .funct3_o       (funct3_o),
        .funct7_o       (funct7_o),
        .shamt_o        (shamt_o),
        .pID_o          (pID_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every payload field is derived from the address so one number identifies a bundle
    function automatic logic [63:0] rs1_of(input logic [31:0] a);
        return {a, ~a};
    endfunction

    task automatic drive_bundle(input logic [31:0] a);
        instAddr_i      = a;
        rdAddr_i        = a[6:2];
        rdWriteEnable_i = a[2];
        rs1ReadData_i   = rs1_of(a);
        rs2ReadData_i   = {~a, a};
        imm_i           = {32'hFFFF_FFFF, a};
        opCode_i        = a[8:2];
        funct3_i        = a[4:2];
        funct7_i        = a[10:4];
        shamt_i         = a[7:2];
        pID_i           = a[3:2];
    endtask

    logic [31:0] q[$];
    logic        exp_ready;
    logic        exp_valid;
    logic        in_x;
    logic        out_x;
    logic [31:0] next_id;

    initial begin
        rst = 1'b1; flush_i = 1'b0; valid_i = 1'b1; ready_i = 1'b0;
        drive_bundle(32'h1234_5678);

        // Reset held two cycles with a valid bundle offered
        step();
        step();
        check("rst_valid_o", valid_o, 0);
        check("rst_ready_o", ready_o, 0);
        check("rst_instAddr_o", instAddr_o, 0);
        check("rst_rs1_o", rs1ReadData_o, 0);
        check("rst_imm_o", imm_o, 0);
        check("rst_rdAddr_o", rdAddr_o, 0);
        check("rst_rdwe_o", rdWriteEnable_o, 0);
        check("rst_pid_o", pID_o, 0);
        valid_i = 1'b0;
        rst = 1'b0;
        #1;
        check("post_rst_ready_o", ready_o, 1);

        // Streaming at full rate
        ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive_bundle(32'h8000_0000 + 32'(4 * k));
            valid_i = 1'b1;
            check("stream_ready_o", ready_o, 1);
            step();
            check("stream_valid_o", valid_o, 1);
            check("stream_instAddr", instAddr_o, 32'h8000_0000 + 32'(4 * k));
            check("stream_rs1", rs1ReadData_o, rs1_of(32'h8000_0000 + 32'(4 * k)));
        end
        valid_i = 1'b0;
        step();
        check("stream_drained", valid_o, 0);

        // Stall: A then B into the skid, C offered while full
        ready_i = 1'b0;
        drive_bundle(32'h8000_0000); valid_i = 1'b1;
        step();
        drive_bundle(32'h8000_0004);
        step();
        check("stall_ready_o", ready_o, 0);
        check("stall_valid_o", valid_o, 1);
        check("stall_hold_A", instAddr_o, 32'h8000_0000);
        drive_bundle(32'h8000_0008);
        step();
        check("stall_still_A", instAddr_o, 32'h8000_0000);
        check("stall_still_full", ready_o, 0);
        valid_i = 1'b0;
        ready_i = 1'b1;
        #1;
        check("stall_ready_not_comb", ready_o, 0);
        step();
        check("stall_then_B", instAddr_o, 32'h8000_0004);
        check("stall_B_valid", valid_o, 1);
        check("stall_ready_back", ready_o, 1);
        step();
        check("stall_C_dropped", valid_o, 0);

        // Flush from TWO with offers on both sides
        ready_i = 1'b0;
        drive_bundle(32'h8000_0000); valid_i = 1'b1;
        step();
        drive_bundle(32'h8000_0004);
        step();
        drive_bundle(32'h8000_000C);
        flush_i = 1'b1; ready_i = 1'b1;
        step();
        flush_i = 1'b0; valid_i = 1'b0;
        check("flush2_valid_o", valid_o, 0);
        check("flush2_ready_o", ready_o, 1);
        check("flush2_rdwe_o", rdWriteEnable_o, 0);
        step();
        check("flush2_stays_empty", valid_o, 0);

        // Flush from ONE beats a concurrent accept
        drive_bundle(32'h8000_0010); valid_i = 1'b1; ready_i = 1'b0;
        step();
        drive_bundle(32'h8000_0014); flush_i = 1'b1;
        check("flush1_ready_during", ready_o, 1);
        step();
        flush_i = 1'b0; valid_i = 1'b0;
        check("flush1_valid_o", valid_o, 0);
        step();
        check("flush1_no_resurrect", valid_o, 0);

        // Field exactness and write-enable qualification
        drive_bundle(32'h8000_0020);
        rdAddr_i = 5'd10; rdWriteEnable_i = 1'b1; imm_i = 64'hFFFF_FFFF_FFFF_F800;
        valid_i = 1'b1; ready_i = 1'b0;
        step();
        valid_i = 1'b0;
        check("qual_rdAddr", rdAddr_o, 10);
        check("qual_rdwe", rdWriteEnable_o, 1);
        check("qual_imm", imm_o, 64'hFFFF_FFFF_FFFF_F800);
        check("qual_opcode", opCode_o, 7'h08);
        ready_i = 1'b1;
        step();
        check("qual_drain_valid", valid_o, 0);
        check("qual_drain_rdwe", rdWriteEnable_o, 0);
        check("qual_rdAddr_held", rdAddr_o, 10);

        // Randomized traffic against a FIFO model
        q.delete();
        next_id = 32'h4000_0000;
        for (int c = 0; c < 10000; c++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 2) != 0);
            flush_i = ($urandom_range(0, 63) == 0);
            drive_bundle(next_id);
            #1;
            exp_ready = (q.size() < 2);
            exp_valid = (q.size() > 0);
            check("rnd_ready_o", ready_o, exp_ready);
            check("rnd_valid_o", valid_o, exp_valid);
            if (q.size() > 0) begin
                check("rnd_instAddr", instAddr_o, q[0]);
                check("rnd_rs1", rs1ReadData_o, rs1_of(q[0]));
            end
            in_x  = valid_i && exp_ready;
            out_x = exp_valid && ready_i;
            if (flush_i) begin
                q.delete();
            end else begin
                if (out_x) void'(q.pop_front());
                if (in_x) q.push_back(next_id);
            end
            if (in_x) next_id = next_id + 32'd4;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
